load_store_unit: RTL

//  Parametrised load/store unit replacing the single-cycle E->M data-memory path of the pipelined core.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_data_align.sv | 78 +++++++
 rtl/load_store_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// mcause codes for memory exceptions, data-width selection codes and small
// decode helpers for access size and exception selection.
package lsu_pkg;

  // Data-width selection codes (DW = 1 << (code + 4)).
  localparam logic [1:0] XLEN_32B = 2'b01;
  localparam logic [1:0] XLEN_64B = 2'b10;

  // mcause values reported for memory exceptions.
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  // REQ2/WAIT2 carry the second beat of a word-crossing split access.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_REQ2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  // Data-path width in bits for a width selection code.
  function automatic int data_width(input logic [1:0] xlen);
    return int'(32'd1 << (32'(xlen) + 32'd4));
  endfunction

  // Number of bytes touched by a funct3 size field.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] nbytes;
    case (size)
      2'd0:    nbytes = 4'd1;
      2'd1:    nbytes = 4'd2;
      2'd2:    nbytes = 4'd4;
      2'd3:    nbytes = 4'd8;
      default: nbytes = 4'd1;
    endcase
    return nbytes;
  endfunction

  function automatic logic [3:0] fault_code(input logic is_store);
    return is_store ? EXC_ST_FAULT : EXC_LD_FAULT;
  endfunction

  function automatic logic [3:0] misalign_code(input logic is_store);
    return is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align
// Combinational lane steering for the load/store unit.
//  off        byte offset of the access inside the bus word
//  size, uns  funct3 size and unsigned-load flag
//  wdata      LSB-justified store data
//  rdata_lo   bus word holding the first byte of a load
//  rdata_hi   following bus word (zero unless the load crosses a word)
//  be_lo/hi   byte enables for the first / following bus word
//  wdata_lo/hi lane-shifted store data for the first / following bus word
//  rdata      load result shifted down and sign/zero-extended
// The access is modelled as a window over two consecutive bus words so an
// access that spills past the end of a word lands naturally in the *_hi half.
module lsu_data_align #(
  parameter int DW = 64,
  localparam int NB = DW / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0] off,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata_lo,
  input  logic [DW-1:0] rdata_hi,
  output logic [NB-1:0] be_lo,
  output logic [NB-1:0] be_hi,
  output logic [DW-1:0] wdata_lo,
  output logic [DW-1:0] wdata_hi,
  output logic [DW-1:0] rdata
);

  logic [2*NB-1:0] mask_s;
  logic [2*NB-1:0] be2_s;
  logic [2*DW-1:0] wd2_s;
  logic [2*DW-1:0] rd2_s;
  logic [DW-1:0]   shifted_s;
  logic [DW-1:0]   ext_mask_s;
  logic            sign_s;

  // Size decode, lane shifts in both directions and load extension.
  always_comb begin
    mask_s     = '0;
    ext_mask_s = '0;
    sign_s     = 1'b0;
    rd2_s      = {rdata_hi, rdata_lo} >> {off, 3'b000};
    shifted_s  = rd2_s[DW-1:0];
    case (size)
      2'd0: begin
        mask_s     = (2*NB)'(8'h01);
        ext_mask_s = DW'(8'hFF);
        sign_s     = shifted_s[7];
      end
      2'd1: begin
        mask_s     = (2*NB)'(8'h03);
        ext_mask_s = DW'(16'hFFFF);
        sign_s     = shifted_s[15];
      end
      2'd2: begin
        mask_s     = (2*NB)'(8'h0F);
        ext_mask_s = DW'(32'hFFFF_FFFF);
        sign_s     = shifted_s[31];
      end
      default: begin
        mask_s     = (2*NB)'(8'hFF);
        ext_mask_s = '1;
        sign_s     = shifted_s[DW-1];
      end
    endcase
    be2_s = mask_s << off;
    wd2_s = {{DW{1'b0}}, wdata} << {off, 3'b000};
    rdata = (shifted_s & ext_mask_s) | ((sign_s && !uns) ? ~ext_mask_s : '0);
  end

  assign be_lo    = be2_s[NB-1:0];
  assign be_hi    = be2_s[2*NB-1:NB];
  assign wdata_lo = wd2_s[DW-1:0];
  assign wdata_hi = wd2_s[2*DW-1:DW];

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle load/store unit between EX and a req/gnt/rvalid data bus.
// Accepts one op from EX, drives the bus, aligns/extends load data, stalls
// the pipeline while busy and reports memory exceptions with mcause codes.
// Optional build macro: LSU_MISALIGNED_SPLIT_EN -- when defined, misaligned
// accesses are performed (two beats if they cross a bus word) instead of
// trapping with a misaligned exception.
// Ports:
//  i_clk, i_rst (async active-low), i_clk_en (freezes all state when low)
//  i_req_valid/i_is_store/i_f3/i_addr/i_wdata  op from EX stage
//  i_flush                                     pipeline flush
//  o_stall                                     hold front of pipeline
//  o_rdata/o_rdata_valid                       load result pulse
//  o_exc_valid/o_exc_code/o_exc_addr           exception pulse, mcause, mtval
//  o_bus_req/we/addr/wdata/be, i_bus_gnt       request channel
//  i_bus_rvalid/i_bus_rdata/i_bus_err          response channel
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [1:0] XLEN           = XLEN_64B,
  parameter int         TIMEOUT_CYCLES = 255,
  localparam int        DW             = data_width(XLEN),
  localparam int        NB             = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_req_valid,
  input  logic          i_is_store,
  input  logic [2:0]    i_f3,
  input  logic [DW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_flush,
  output logic          o_stall,
  output logic [DW-1:0] o_rdata,
  output logic          o_rdata_valid,
  output logic          o_exc_valid,
  output logic [3:0]    o_exc_code,
  output logic [DW-1:0] o_exc_addr,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [DW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  output logic [NB-1:0] o_bus_be,
  input  logic          i_bus_gnt,
  input  logic          i_bus_rvalid,
  input  logic [DW-1:0] i_bus_rdata,
  input  logic          i_bus_err
);

  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit DW32 = (DW == 32);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e    state_r, state_n;
  logic          is_store_r, uns_r, flushed_r, flushed_n;
  logic [1:0]    size_r;
  logic [DW-1:0] addr_r, wdata_r, lo_r, rdata_r, exc_addr_r, exc_addr_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic          rdata_valid_r, exc_valid_r;
  logic [3:0]    exc_code_r, exc_code_n;
  logic          accept_s, set_rdv_s, set_exc_s, lo_load_s;
  logic          illegal_s, misalign_s, cross_s, timeout_s, req_phase_s, hi_beat_s;
  logic [3:0]    low_s;
  logic [DW-1:0] align_lo_s, align_hi_s, align_rdata_s, wdata_lo_s, wdata_hi_s, word_addr_s;
  logic [NB-1:0] be_lo_s, be_hi_s;

  // The second beat of a split load merges the saved first word with the bus word.
  assign align_lo_s = (state_r == ST_WAIT2) ? lo_r : i_bus_rdata;
  assign align_hi_s = (state_r == ST_WAIT2) ? i_bus_rdata : '0;

  lsu_data_align #(.DW(DW)) u_align (
    .off      (addr_r[OW-1:0]),
    .size     (size_r),
    .uns      (uns_r),
    .wdata    (wdata_r),
    .rdata_lo (align_lo_s),
    .rdata_hi (align_hi_s),
    .be_lo    (be_lo_s),
    .be_hi    (be_hi_s),
    .wdata_lo (wdata_lo_s),
    .wdata_hi (wdata_hi_s),
    .rdata    (align_rdata_s)
  );

  // Request decode for the op offered in IDLE; D, f3=111 and LWU do not exist on a 32-bit bus.
  always_comb begin
    low_s      = 4'(i_addr[OW-1:0]);
    misalign_s = (low_s & (size_bytes(i_f3[1:0]) - 4'd1)) != 4'd0;
    illegal_s  = (i_f3 == 3'b111) ||
                 (DW32 && ((i_f3[1:0] == 2'd3) || (!i_is_store && (i_f3 == 3'b110))));
  end

  assign cross_s     = SPLIT_EN && (be_hi_s != '0);
  assign timeout_s   = TO_EN && (cnt_r == CNT_LAST);
  assign req_phase_s = (state_r == ST_REQ) || (state_r == ST_REQ2);
  assign hi_beat_s   = (state_r == ST_REQ2);
  assign word_addr_s = {addr_r[DW-1:OW], {OW{1'b0}}};

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_n    = state_r;
    flushed_n  = flushed_r;
    cnt_n      = cnt_r;
    accept_s   = 1'b0;
    set_rdv_s  = 1'b0;
    set_exc_s  = 1'b0;
    lo_load_s  = 1'b0;
    exc_code_n = fault_code(is_store_r);
    exc_addr_n = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req_valid) begin
          accept_s   = 1'b1;
          flushed_n  = 1'b0;
          exc_addr_n = i_addr;
          if (illegal_s) begin
            state_n    = ST_RESP;
            set_exc_s  = 1'b1;
            exc_code_n = fault_code(i_is_store);
          end else if (misalign_s && !SPLIT_EN) begin
            state_n    = ST_RESP;
            set_exc_s  = 1'b1;
            exc_code_n = misalign_code(i_is_store);
          end else begin
            state_n = ST_REQ;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ, ST_REQ2: begin
        // A grant wins over a same-cycle flush: the beat is then owed and its response discarded.
        if (i_bus_gnt) begin
          state_n   = (state_r == ST_REQ) ? ST_WAIT : ST_WAIT2;
          cnt_n     = '0;
          flushed_n = flushed_r | i_flush;
        end else if (i_flush) begin
          state_n = ST_IDLE;
        end else begin
          state_n = state_r;
        end
      end
      ST_WAIT, ST_WAIT2: begin
        cnt_n     = cnt_r + CW'(1'b1);
        flushed_n = flushed_r | i_flush;
        if (i_bus_rvalid) begin
          if (flushed_r || i_flush) begin
            state_n = ST_IDLE;
          end else if (i_bus_err) begin
            state_n   = ST_RESP;
            set_exc_s = 1'b1;
          end else if ((state_r == ST_WAIT) && cross_s) begin
            state_n   = ST_REQ2;
            lo_load_s = 1'b1;
          end else begin
            state_n   = ST_RESP;
            set_rdv_s = !is_store_r;
          end
        end else if (timeout_s) begin
          if (flushed_r || i_flush) begin
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_RESP;
            set_exc_s = 1'b1;
          end
        end else begin
          state_n = state_r;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, latched op and result/exception registers; frozen while i_clk_en is low.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r       <= ST_IDLE;
      flushed_r     <= 1'b0;
      cnt_r         <= '0;
      is_store_r    <= 1'b0;
      uns_r         <= 1'b0;
      size_r        <= 2'd0;
      addr_r        <= '0;
      wdata_r       <= '0;
      lo_r          <= '0;
      rdata_r       <= '0;
      rdata_valid_r <= 1'b0;
      exc_valid_r   <= 1'b0;
      exc_code_r    <= 4'd0;
      exc_addr_r    <= '0;
    end else if (i_clk_en) begin
      state_r       <= state_n;
      flushed_r     <= flushed_n;
      cnt_r         <= cnt_n;
      rdata_valid_r <= set_rdv_s;
      exc_valid_r   <= set_exc_s;
      if (accept_s) begin
        is_store_r <= i_is_store;
        uns_r      <= i_f3[2];
        size_r     <= i_f3[1:0];
        addr_r     <= i_addr;
        wdata_r    <= i_wdata;
      end
      if (lo_load_s) lo_r <= i_bus_rdata;
      if (set_rdv_s) rdata_r <= align_rdata_s;
      if (set_exc_s) begin
        exc_code_r <= exc_code_n;
        exc_addr_r <= exc_addr_n;
      end
    end
  end

  assign o_stall       = ((state_r != ST_IDLE) && (state_r != ST_RESP)) ||
                         ((state_r == ST_IDLE) && i_req_valid && i_clk_en);
  assign o_rdata       = rdata_r;
  assign o_rdata_valid = rdata_valid_r;
  assign o_exc_valid   = exc_valid_r;
  assign o_exc_code    = exc_code_r;
  assign o_exc_addr    = exc_addr_r;
  assign o_bus_req     = req_phase_s;
  assign o_bus_we      = req_phase_s && is_store_r;
  assign o_bus_addr    = req_phase_s ? (word_addr_s + (hi_beat_s ? DW'(NB) : '0)) : '0;
  assign o_bus_be      = req_phase_s ? (hi_beat_s ? be_hi_s : be_lo_s) : '0;
  assign o_bus_wdata   = req_phase_s ? (hi_beat_s ? wdata_hi_s : wdata_lo_s) : '0;

endmodule
